// File: rtl/hatch_seq.sv
// Incubation sequencer for the 8x8 dot-matrix frame interface.
// It debounces the start key and the warm switch, times each stage in 1 s ticks and steps the frame index.
module hatch_seq #(
  parameter int CLK_HZ     = 1000,
  parameter int DEB_CYC    = 20,
  parameter int STAGE_SEC  = 5,
  parameter int FAIL_SEC   = 3,
  parameter int LAST_FRAME = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_temp,
  output logic [3:0] num,
  output logic       st,
  output logic       temp,
  output logic       done,
  output logic       fail
);

  localparam int PW = (CLK_HZ    > 1) ? $clog2(CLK_HZ)    : 1;
  localparam int DW = (DEB_CYC   > 1) ? $clog2(DEB_CYC)   : 1;
  localparam int SW = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
  localparam int CW = (FAIL_SEC  > 1) ? $clog2(FAIL_SEC)  : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  // bit 0 = start key, bit 1 = warm switch
  logic [1:0]    raw_s;
  logic [1:0]    meta_r;
  logic [1:0]    sync_r;
  logic [1:0]    deb_r;
  logic [DW-1:0] deb_cnt_r [2];
  logic          start_prev_r;
  logic          start_pulse_s;
  logic          warm_s;
  logic          tick_s;

  state_t        state_r,  state_s;
  logic [PW-1:0] presc_r,  presc_s, presc_step_s;
  logic [SW-1:0] sec_r,    sec_s;
  logic [CW-1:0] cold_r,   cold_s;
  logic [3:0]    num_r,    num_s, num_inc_s;
  logic          st_r,     st_s;
  logic          temp_r,   temp_s;
  logic          done_r,   done_s;
  logic          fail_r,   fail_s;

  assign raw_s = {key_temp, key_start};

  // Two-flop synchroniser for both raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Debouncers: a new level is accepted only after DEB_CYC stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= {DW{1'b0}};
        end else if (deb_cnt_r[i] == DW'(DEB_CYC - 1)) begin
          deb_r[i]     <= sync_r[i];
          deb_cnt_r[i] <= {DW{1'b0}};
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Previous debounced start level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_prev_r <= 1'b0;
    else        start_prev_r <= deb_r[0];
  end

  assign start_pulse_s = deb_r[0] & ~start_prev_r;
  assign warm_s        = deb_r[1];
  assign tick_s        = (presc_r == PW'(CLK_HZ - 1));
  assign presc_step_s  = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
  assign num_inc_s     = num_r + 4'd1;

  // Next-state, counter and output-register logic
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    sec_s   = sec_r;
    cold_s  = cold_r;
    num_s   = num_r;
    st_s    = st_r;
    temp_s  = temp_r;
    done_s  = 1'b0;
    fail_s  = 1'b0;

    case (state_r)
      S_IDLE: begin
        presc_s = {PW{1'b0}};
        sec_s   = {SW{1'b0}};
        cold_s  = {CW{1'b0}};
        num_s   = 4'd0;
        if (start_pulse_s) state_s = S_RUN;
        else               state_s = S_IDLE;
      end
      S_RUN: begin
        // The prescaler keeps running so a tick coinciding with a pause press is lost
        presc_s = presc_step_s;
        if (start_pulse_s) begin
          state_s = S_PAUSE;
        end else if (warm_s) begin
          cold_s = {CW{1'b0}};
          if (tick_s) begin
            if (sec_r == SW'(STAGE_SEC - 1)) begin
              sec_s = {SW{1'b0}};
              num_s = num_inc_s;
              if (num_inc_s == 4'(LAST_FRAME)) state_s = S_DONE;
              else                             state_s = S_RUN;
            end else begin
              sec_s = sec_r + SW'(1);
            end
          end else begin
            sec_s = sec_r;
          end
        end else begin
          if (tick_s) begin
            if (cold_r == CW'(FAIL_SEC - 1)) state_s = S_FAIL;
            else                             cold_s  = cold_r + CW'(1);
          end else begin
            cold_s = cold_r;
          end
        end
      end
      S_PAUSE: begin
        if (start_pulse_s) state_s = S_RUN;
        else               state_s = S_PAUSE;
      end
      S_DONE, S_FAIL: begin
        presc_s = presc_step_s;
        if (start_pulse_s) begin
          state_s = S_IDLE;
          num_s   = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        num_s   = 4'd0;
      end
    endcase

    // Outputs are registered from the state being entered
    case (state_s)
      S_IDLE: begin
        st_s   = 1'b0;
        temp_s = 1'b0;
      end
      S_RUN, S_PAUSE: begin
        st_s   = 1'b1;
        temp_s = warm_s;
      end
      S_DONE: begin
        st_s   = 1'b1;
        temp_s = warm_s;
        done_s = 1'b1;
      end
      S_FAIL: begin
        temp_s = 1'b0;
        fail_s = 1'b1;
        if (state_r != S_FAIL) st_s = 1'b1;
        else if (tick_s)       st_s = ~st_r;
        else                   st_s = st_r;
      end
      default: begin
        st_s   = 1'b0;
        temp_s = 1'b0;
      end
    endcase
  end

  // FSM, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      presc_r <= {PW{1'b0}};
      sec_r   <= {SW{1'b0}};
      cold_r  <= {CW{1'b0}};
      num_r   <= 4'd0;
      st_r    <= 1'b0;
      temp_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      sec_r   <= sec_s;
      cold_r  <= cold_s;
      num_r   <= num_s;
      st_r    <= st_s;
      temp_r  <= temp_s;
      done_r  <= done_s;
      fail_r  <= fail_s;
    end
  end

  assign num  = num_r;
  assign st   = st_r;
  assign temp = temp_r;
  assign done = done_r;
  assign fail = fail_r;

endmodule

// File: tb/tb_hatch_seq.sv
// Directed bench for hatch_seq: expectations are queued with a target cycle and checked on the falling edge.
module tb_hatch_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start;
  logic       key_temp;
  logic [3:0] num;
  logic       st;
  logic       temp;
  logic       done;
  logic       fail;

  hatch_seq #(
    .CLK_HZ(4), .DEB_CYC(2), .STAGE_SEC(2), .FAIL_SEC(3), .LAST_FRAME(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_temp(key_temp),
    .num(num), .st(st), .temp(temp), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad   = 0;
  int         q_at  [$];
  logic [7:0] q_val [$];
  logic [7:0] q_msk [$];
  string      q_tag [$];
  logic [7:0] obs;

  localparam logic [7:0] M_ALL = 8'hFF;
  localparam logic [7:0] M_NUM = 8'hF0;
  localparam logic [7:0] M_TMP = 8'h04;
  localparam logic [7:0] M_NF  = 8'hF1;

  function automatic logic [7:0] v(input int n, input logic s, input logic t,
                                   input logic d, input logic f);
    return {n[3:0], s, t, d, f};
  endfunction

  task automatic expect_at(input int at, input logic [7:0] m, input logic [7:0] val,
                           input string tag);
    q_at.push_back(at);
    q_msk.push_back(m);
    q_val.push_back(val & m);
    q_tag.push_back(tag);
  endtask

  // Scoreboard: compare every entry due this cycle, away from the rising edge
  always @(negedge clk) begin
    for (int i = q_at.size() - 1; i >= 0; i--) begin
      if (q_at[i] <= cyc) begin
        obs = {num, st, temp, done, fail} & q_msk[i];
        total++;
        if (q_at[i] < cyc) begin
          bad++;
          $error("FAIL %s: missed check cycle %0d (now %0d)", q_tag[i], q_at[i], cyc);
        end else begin
          assert (obs === q_val[i]) else begin
            bad++;
            $error("FAIL %s @%0d: observed {num,st,temp,done,fail}=%h expected %h (mask %h)",
                   q_tag[i], cyc, obs, q_val[i], q_msk[i]);
          end
        end
        q_at.delete(i);
        q_msk.delete(i);
        q_val.delete(i);
        q_tag.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic press(input int hold);
    key_start = 1'b1;
    repeat (hold) step();
    key_start = 1'b0;
  endtask

  int c;
  int e;

  initial begin
    rst_n     = 1'b0;
    key_start = 1'b0;
    key_temp  = 1'b0;
    repeat (3) step();
    expect_at(cyc, M_ALL, v(0, 0, 0, 0, 0), "reset_state");
    rst_n    = 1'b1;
    key_temp = 1'b1;
    repeat (10) step();

    // Reset asserted mid-run at frame 5
    c = cyc; e = c + 5;
    expect_at(e - 1,  M_ALL, v(0, 0, 0, 0, 0), "idle_before_run");
    expect_at(e,      M_ALL, v(0, 1, 1, 0, 0), "run_entry");
    expect_at(e + 41, M_ALL, v(5, 1, 1, 0, 0), "num5_before_reset");
    press(4);
    wait_until(e + 42);
    rst_n = 1'b0;
    expect_at(cyc, M_ALL, v(0, 0, 0, 0, 0), "async_reset");
    step();
    rst_n = 1'b1;
    repeat (20) step();
    expect_at(cyc, M_ALL, v(0, 0, 0, 0, 0), "idle_after_reset");

    // One-cycle glitch on the start key is ignored
    step();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    repeat (15) step();
    expect_at(cyc, M_ALL, v(0, 0, 0, 0, 0), "glitch_ignored");

    // Full warm hatch: frame step every 8 cycles, done after 88
    c = cyc; e = c + 5;
    expect_at(e - 1, M_ALL, v(0, 0, 0, 0, 0), "press4_latency");
    expect_at(e,     M_ALL, v(0, 1, 1, 0, 0), "hatch_entry");
    for (int k = 1; k <= 10; k++) begin
      expect_at(e + 8 * k - 1, M_NUM, v(k - 1, 0, 0, 0, 0), "stage_hold");
      expect_at(e + 8 * k,     M_NUM, v(k,     0, 0, 0, 0), "stage_step");
    end
    expect_at(e + 87,  M_ALL, v(10, 1, 1, 0, 0), "before_done");
    expect_at(e + 88,  M_ALL, v(11, 1, 1, 1, 0), "done_entry");
    expect_at(e + 120, M_ALL, v(11, 1, 1, 1, 0), "done_held");
    press(4);
    wait_until(e + 121);

    // Start in DONE returns to IDLE
    c = cyc;
    expect_at(c + 4, M_ALL, v(11, 1, 1, 1, 0), "done_before_start");
    expect_at(c + 5, M_ALL, v(0, 0, 0, 0, 0),  "done_to_idle");
    press(4);
    wait_until(c + 12);

    // Cold for 12 cycles: three cold ticks fail, then st blinks
    c = cyc; e = c + 5;
    expect_at(e,      M_ALL, v(1 - 1, 1, 1, 0, 0), "cold_run_entry");
    expect_at(e + 23, M_ALL, v(1, 1, 0, 0, 0), "cold_in_run");
    expect_at(e + 24, M_ALL, v(1, 1, 0, 0, 1), "fail_entry");
    expect_at(e + 27, M_ALL, v(1, 1, 0, 0, 1), "fail_st_high");
    expect_at(e + 28, M_ALL, v(1, 0, 0, 0, 1), "fail_blink_off");
    expect_at(e + 31, M_ALL, v(1, 0, 0, 0, 1), "fail_st_low");
    expect_at(e + 32, M_ALL, v(1, 1, 0, 0, 1), "fail_blink_on");
    press(4);
    wait_until(e + 10);
    key_temp = 1'b0;
    wait_until(e + 22);
    key_temp = 1'b1;
    wait_until(e + 34);

    // Start in FAIL returns to IDLE
    c = cyc;
    expect_at(c + 4, M_NF,  v(1, 0, 0, 0, 1), "fail_before_start");
    expect_at(c + 5, M_ALL, v(0, 0, 0, 0, 0), "fail_to_idle");
    press(4);
    wait_until(c + 20);

    // Short cold spell holds the stage, then pause at frame 4 for 110 cycles
    c = cyc; e = c + 5;
    expect_at(e,       M_ALL, v(0, 1, 1, 0, 0), "run2_entry");
    expect_at(e + 18,  M_TMP, v(0, 0, 0, 0, 0), "temp_follows_cold");
    expect_at(e + 23,  M_ALL, v(1, 1, 1, 0, 0), "cold_holds_stage");
    expect_at(e + 24,  M_ALL, v(2, 1, 1, 0, 0), "sec_resumes");
    expect_at(e + 40,  M_NUM, v(4, 0, 0, 0, 0), "num4");
    expect_at(e + 45,  M_ALL, v(4, 1, 1, 0, 0), "pause_entry");
    expect_at(e + 60,  M_ALL, v(4, 1, 1, 0, 0), "pause_frozen_a");
    expect_at(e + 100, M_ALL, v(4, 1, 1, 0, 0), "pause_frozen_b");
    expect_at(e + 150, M_ALL, v(4, 1, 1, 0, 0), "pause_frozen_c");
    expect_at(e + 157, M_ALL, v(4, 1, 1, 0, 0), "resume_pending");
    expect_at(e + 158, M_ALL, v(5, 1, 1, 0, 0), "resume_step");
    expect_at(e + 165, M_NUM, v(5, 0, 0, 0, 0), "after_resume_hold");
    expect_at(e + 166, M_NUM, v(6, 0, 0, 0, 0), "after_resume_step");
    press(4);
    wait_until(e + 10);
    key_temp = 1'b0;
    wait_until(e + 18);
    key_temp = 1'b1;
    wait_until(e + 41);
    press(4);
    wait_until(e + 151);
    press(4);
    wait_until(e + 167);

    for (int i = 0; i < 50 && q_at.size() != 0; i++) step();
    if (q_at.size() != 0) begin
      total += q_at.size();
      bad   += q_at.size();
      $error("FAIL drain: %0d checks still pending, expected 0", q_at.size());
    end else begin
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
